// File: rtl/cdf_pipeline.sv
`default_nettype none
// cdf_pipeline: streams a 256-bin 16-bit histogram from M1 and writes its 20-bit running CDF to M2.
// Define CDF_SATURATE_EN to clamp sums at 20'hFFFFF and raise a sticky overflow flag instead of wrapping.
module cdf_pipeline #(
   parameter logic [15:0] HIST_BASE = 16'h0000,
   parameter logic [15:0] CDF_BASE  = 16'h0000
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         start,
   output logic [15:0]  M1_ReadAddress,
   input  logic [127:0] M1_ReadBus,
   output logic         M2_WriteEnable,
   output logic [15:0]  M2_WriteAddress,
   output logic [127:0] M2_WriteBus,
   output logic [19:0]  CdfMin,
   output logic [19:0]  divisor,
   output logic         busy,
   output logic         done,
   output logic         overflow
);

`ifdef CDF_SATURATE_EN
   localparam int SUM_W = 21;
`else
   localparam int SUM_W = 20;
`endif

   typedef enum logic [2:0] {IDLE, RD, LO, HI, FIN} state_t;

   state_t            state;
   state_t            state_nxt;
   logic [4:0]        idx;
   logic [19:0]       running;
   logic [19:0]       hi_lanes [4];
   logic [19:0]       acc;
   logic [SUM_W-1:0]  sum_v;
   logic [19:0]       cdf [8];
   logic [19:0]       first_nz;
   logic              any_nz;
   logic [19:0]       span;
`ifdef CDF_SATURATE_EN
   logic [7:0]        lane_ovf;
`endif

   // Eight prefix sums of the current word added to the running total.
   always_comb begin
      acc      = '0;
      sum_v    = '0;
      first_nz = '0;
      any_nz   = 1'b0;
`ifdef CDF_SATURATE_EN
      lane_ovf = '0;
`endif
      for (int j = 0; j < 8; j++) begin
         acc   = acc + 20'(M1_ReadBus[16*j +: 16]);
         sum_v = SUM_W'(running) + SUM_W'(acc);
`ifdef CDF_SATURATE_EN
         lane_ovf[j] = sum_v[20];
         cdf[j]      = sum_v[20] ? 20'hFFFFF : sum_v[19:0];
`else
         cdf[j]      = sum_v;
`endif
         if (!any_nz && cdf[j] != 20'd0) begin
            first_nz = cdf[j];
            any_nz   = 1'b1;
         end
      end
   end

   assign span = hi_lanes[3] - CdfMin;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt       = state;
      busy            = 1'b1;
      done            = 1'b0;
      M2_WriteEnable  = 1'b0;
      M2_WriteAddress = 16'h0000;
      M2_WriteBus     = '0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) state_nxt = RD;
         end
         RD: state_nxt = LO;
         LO: begin
            state_nxt       = HI;
            M2_WriteEnable  = 1'b1;
            M2_WriteAddress = CDF_BASE + {10'b0, idx, 1'b0};
            M2_WriteBus     = {12'h000, cdf[3], 12'h000, cdf[2],
                               12'h000, cdf[1], 12'h000, cdf[0]};
         end
         HI: begin
            state_nxt       = (idx == 5'd31) ? FIN : RD;
            M2_WriteEnable  = 1'b1;
            M2_WriteAddress = CDF_BASE + {10'b0, idx, 1'b1};
            M2_WriteBus     = {12'h000, hi_lanes[3], 12'h000, hi_lanes[2],
                               12'h000, hi_lanes[1], 12'h000, hi_lanes[0]};
         end
         FIN: begin
            state_nxt = IDLE;
            done      = 1'b1;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // The read address is registered on entry to RD so it holds through LO/HI/IDLE.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         idx            <= '0;
         running        <= '0;
         CdfMin         <= '0;
         divisor        <= 20'd1;
         M1_ReadAddress <= '0;
         for (int k = 0; k < 4; k++) hi_lanes[k] <= '0;
      end else begin
         case (state)
            IDLE: if (start) begin
               idx            <= '0;
               running        <= '0;
               CdfMin         <= '0;
               M1_ReadAddress <= HIST_BASE;
            end
            LO: begin
               for (int k = 0; k < 4; k++) hi_lanes[k] <= cdf[4+k];
               if (CdfMin == 20'd0 && any_nz) CdfMin <= first_nz;
            end
            HI: begin
               running <= hi_lanes[3];
               if (idx == 5'd31) begin
                  divisor <= (span == 20'd0) ? 20'd1 : span;
               end else begin
                  idx            <= idx + 5'd1;
                  M1_ReadAddress <= HIST_BASE + {11'b0, 5'(idx + 5'd1)};
               end
            end
            default: ;
         endcase
      end
   end

`ifdef CDF_SATURATE_EN
   always_ff @(posedge clock or posedge reset) begin
      if (reset)                        overflow <= 1'b0;
      else if (state == IDLE && start)  overflow <= 1'b0;
      else if (state == LO && |lane_ovf) overflow <= 1'b1;
   end
`else
   assign overflow = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cdf_pipeline.sv
`default_nettype none
// tb_cdf_pipeline: directed self-checking bench for cdf_pipeline with an M1 read model and M2 write log.
module tb_cdf_pipeline;
   localparam logic [15:0] HB = 16'h0100;
   localparam logic [15:0] CB = 16'h2000;

   logic         clock = 1'b0;
   logic         reset;
   logic         start;
   logic [15:0]  M1_ReadAddress;
   logic [127:0] M1_ReadBus;
   logic         M2_WriteEnable;
   logic [15:0]  M2_WriteAddress;
   logic [127:0] M2_WriteBus;
   logic [19:0]  CdfMin;
   logic [19:0]  divisor;
   logic         busy;
   logic         done;
   logic         overflow;

   int n_cmp = 0;
   int n_bad = 0;
   int wr_total = 0;
   int base;
   int first_done;
   int n_done;

   logic [15:0]  hist [256];
   logic [15:0]  log_addr [1024];
   logic [127:0] log_data [1024];

   always #5 clock = ~clock;

   cdf_pipeline #(.HIST_BASE(HB), .CDF_BASE(CB)) dut (
      .clock(clock), .reset(reset), .start(start),
      .M1_ReadAddress(M1_ReadAddress), .M1_ReadBus(M1_ReadBus),
      .M2_WriteEnable(M2_WriteEnable), .M2_WriteAddress(M2_WriteAddress),
      .M2_WriteBus(M2_WriteBus), .CdfMin(CdfMin), .divisor(divisor),
      .busy(busy), .done(done), .overflow(overflow)
   );

   function automatic logic [127:0] m1_word(input logic [15:0] off);
      logic [127:0] r;
      r = '0;
      if (off < 16'd32)
         for (int j = 0; j < 8; j++) r[16*j +: 16] = hist[int'(off)*8 + j];
      return r;
   endfunction

   // Synchronous SRAM: data appears one cycle after the address.
   always @(posedge clock) M1_ReadBus <= m1_word(M1_ReadAddress - HB);

   always @(posedge clock) begin
      if (M2_WriteEnable === 1'b1) begin
         if (wr_total < 1024) begin
            log_addr[wr_total] <= M2_WriteAddress;
            log_data[wr_total] <= M2_WriteBus;
         end
         wr_total <= wr_total + 1;
      end
   end

   // Hand formulas for each directed pattern: 0 all-4, 1 bin37=500, 2 zeros, 3 all-FFFF.
   function automatic logic [19:0] exp_cdf(input int mode, input int k);
      longint t;
      case (mode)
         0:       t = 4 * (k + 1);
         1:       t = (k >= 37) ? 500 : 0;
         2:       t = 0;
         default: t = 65535 * longint'(k + 1);
      endcase
`ifdef CDF_SATURATE_EN
      if (t > 20'hFFFFF) t = 20'hFFFFF;
`endif
      return 20'(t);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic fill(input int mode);
      for (int k = 0; k < 256; k++)
         case (mode)
            0:       hist[k] = 16'd4;
            1:       hist[k] = (k == 37) ? 16'd500 : 16'd0;
            2:       hist[k] = 16'd0;
            default: hist[k] = 16'hFFFF;
         endcase
   endtask

   // Start a run and watch a fixed 110-cycle window; cycle 1 follows the accepting edge.
   task automatic run(input int retrig);
      first_done = 0;
      n_done     = 0;
      @(negedge clock);
      base  = wr_total;
      start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      for (int cyc = 1; cyc <= 110; cyc++) begin
         if (done === 1'b1) begin
            n_done++;
            if (first_done == 0) first_done = cyc;
         end
         start = (cyc == retrig) ? 1'b1 : 1'b0;
         @(posedge clock); #1;
      end
      start = 1'b0;
   endtask

   task automatic check_run(input string tag, input int mode, input logic [19:0] emin,
                            input logic [19:0] ediv, input logic eovf);
      int bad_a;
      int bad_d;
      bad_a = 0;
      bad_d = 0;
      chk({tag, " done_cycle"}, first_done, 97);
      chk({tag, " done_pulses"}, n_done, 1);
      chk({tag, " write_count"}, wr_total - base, 64);
      for (int w = 0; w < 64; w++) begin
         if (log_addr[base+w] !== CB + 16'(w)) bad_a++;
         for (int l = 0; l < 4; l++)
            if (log_data[base+w][32*l +: 32] !== {12'h000, exp_cdf(mode, 4*w + l)}) bad_d++;
      end
      chk({tag, " bad_addresses"}, bad_a, 0);
      chk({tag, " bad_cdf_lanes"}, bad_d, 0);
      chk({tag, " CdfMin"}, CdfMin, emin);
      chk({tag, " divisor"}, divisor, ediv);
      chk({tag, " overflow"}, overflow, eovf);
      chk({tag, " busy_after"}, busy, 0);
      chk({tag, " m1_addr_held"}, M1_ReadAddress, HB + 16'd31);
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      fill(2);
      repeat (3) @(posedge clock);
      #1;
      chk("rst CdfMin", CdfMin, 0);
      chk("rst divisor", divisor, 1);
      chk("rst overflow", overflow, 0);
      chk("rst busy", busy, 0);
      chk("rst done", done, 0);
      chk("rst we", M2_WriteEnable, 0);
      chk("rst m1_addr", M1_ReadAddress, 0);
      chk("rst m2_addr", M2_WriteAddress, 0);
      chk("rst m2_bus_nz", {31'b0, |M2_WriteBus}, 0);
      @(negedge clock);
      reset = 1'b0;

      fill(0); run(0); check_run("all4", 0, 20'd4, 20'd1020, 1'b0);
      fill(1); run(0); check_run("bin37", 1, 20'd500, 20'd1, 1'b0);
      fill(2); run(0); check_run("zeros", 2, 20'd0, 20'd1, 1'b0);

      fill(3); run(0);
`ifdef CDF_SATURATE_EN
      check_run("allffff", 3, 20'd65535, 20'd983040, 1'b1);
      chk("allffff cdf16", log_data[base+4][19:0], 20'hFFFFF);
`else
      check_run("allffff", 3, 20'd65535, 20'hEFF01, 1'b0);
      chk("allffff cdf16", log_data[base+4][19:0], 20'd65519);
`endif
      chk("allffff cdf15", log_data[base+3][115:96], 20'd1048560);

      // Abort a run in cycle 40 with an asynchronous reset between clock edges.
      fill(0);
      @(negedge clock);
      start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      repeat (39) @(posedge clock);
      #3;
      chk("abort busy_before", busy, 1);
      reset = 1'b1;
      #1;
      chk("abort busy", busy, 0);
      chk("abort we", M2_WriteEnable, 0);
      chk("abort m1_addr", M1_ReadAddress, 0);
      chk("abort CdfMin", CdfMin, 0);
      @(negedge clock);
      reset = 1'b0;
      run(0); check_run("after_abort", 0, 20'd4, 20'd1020, 1'b0);

      run(10); check_run("retrigger", 0, 20'd4, 20'd1020, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
`default_nettype wire
